// File: rtl/pool_seq_ctrl.sv
// Sequencer for the 2x2/stride-2 pooling datapath: walks a row-major feature map and
// steers the pooling unit and its partial-result register file. Optional macro: POOL_SEQ_STALL_CNT_EN.
module pool_seq_ctrl #(
   parameter int MAX_COLS = 32,
   parameter int MAX_ROWS = 32,
   parameter int DIM_W    = 6,
   parameter int ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_rows,
   input  logic [DIM_W-1:0]  cfg_cols,
   input  logic              sys_valid,
   output logic              x_sel,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              wr_en,
   output logic              wr_src,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              pool_en,
   output logic              out_valid,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
`ifdef POOL_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [DIM_W-1:0]  r_rows;
   logic [DIM_W-1:0]  r_cols;
   logic [DIM_W-1:0]  r_row;
   logic [DIM_W-1:0]  r_col;
   logic              r_cfg_err;

   logic              w_rows_ok;
   logic              w_cols_ok;
   logic              w_cfg_ok;
   logic              w_accept;
   logic              w_reject;
   logic              w_consume;
   logic              w_col_end;
   logic              w_row_end;
   logic [ADDR_W-1:0] w_p;

   // A dimension is usable only if it is a non-zero even number that fits the datapath
   assign w_rows_ok = (cfg_rows != '0) && !cfg_rows[0] && (cfg_rows <= DIM_W'(MAX_ROWS));
   assign w_cols_ok = (cfg_cols != '0) && !cfg_cols[0] && (cfg_cols <= DIM_W'(MAX_COLS));
   assign w_cfg_ok  = w_rows_ok && w_cols_ok;

   assign w_accept  = (r_state == ST_IDLE) && start && w_cfg_ok;
   assign w_reject  = (r_state == ST_IDLE) && start && !w_cfg_ok;
   assign w_consume = (r_state == ST_RUN) && sys_valid;

   assign w_col_end = (r_col == r_cols - DIM_W'(1));
   assign w_row_end = (r_row == r_rows - DIM_W'(1));
   assign w_p       = ADDR_W'(r_col >> 1);

   assign cfg_err   = r_cfg_err;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      x_sel       = 1'b0;
      rd_addr     = '0;
      wr_en       = 1'b0;
      wr_src      = 1'b0;
      wr_addr     = '0;
      pool_en     = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            busy = 1'b1;
            if (sys_valid) begin
               // Top-left seeds the partial, the next two fold into it, the last emits
               case ({r_row[0], r_col[0]})
                  2'b00: begin
                     wr_en   = 1'b1;
                     wr_src  = 1'b0;
                     wr_addr = w_p;
                  end
                  2'b01, 2'b10: begin
                     pool_en = 1'b1;
                     x_sel   = 1'b1;
                     rd_addr = w_p;
                     wr_en   = 1'b1;
                     wr_src  = 1'b1;
                     wr_addr = w_p;
                  end
                  default: begin
                     pool_en   = 1'b1;
                     x_sel     = 1'b1;
                     rd_addr   = w_p;
                     out_valid = 1'b1;
                  end
               endcase
               if (w_col_end && w_row_end) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rows    <= '0;
         r_cols    <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_reject;
         if (w_accept) begin
            r_rows <= cfg_rows;
            r_cols <= cfg_cols;
            r_row  <= '0;
            r_col  <= '0;
         end else if (w_consume) begin
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_row_end ? '0 : r_row + DIM_W'(1);
            end else begin
               r_col <= r_col + DIM_W'(1);
            end
         end
      end
   end

`ifdef POOL_SEQ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of RUN cycles without data; held after the map until the next start
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_stall_cnt <= '0;
      end else if (w_accept) begin
         r_stall_cnt <= '0;
      end else if ((r_state == ST_RUN) && !sys_valid && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl: a cycle model pushes the expected control vector per
// cycle onto a scoreboard queue, which is popped and compared against the DUT mid-cycle.
module tb_pool_seq_ctrl;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] cfg_rows = '0;
   logic [5:0] cfg_cols = '0;
   logic       sys_valid = 1'b0;
   logic       x_sel;
   logic [3:0] rd_addr;
   logic       wr_en;
   logic       wr_src;
   logic [3:0] wr_addr;
   logic       pool_en;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic       cfg_err;
`ifdef POOL_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   pool_seq_ctrl #(.MAX_COLS(32), .MAX_ROWS(32), .DIM_W(6), .ADDR_W(4)) dut (
      .clk(clk), .nrst(nrst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
      .sys_valid(sys_valid), .x_sel(x_sel), .rd_addr(rd_addr), .wr_en(wr_en), .wr_src(wr_src),
      .wr_addr(wr_addr), .pool_en(pool_en), .out_valid(out_valid), .busy(busy), .done(done),
      .cfg_err(cfg_err)
`ifdef POOL_SEQ_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] sb[$];

   // Reference model state
   int m_state = 0;  // 0 idle, 1 run, 2 done
   int m_rows = 0, m_cols = 0, m_row = 0, m_col = 0, m_elem = 0, m_stall = 0;
   bit m_err = 0;

   // Observed statistics, cleared per scenario
   int ov_cnt, busy_cnt, wr_cnt, done_cnt, err_cnt, max_ra, max_wa, wraps, last_wa;
   int ov_idx[$];
   int wa_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pack(bit xs, int ra, bit we, bit ws, int wa, bit pe, bit ov,
                                        bit bz, bit dn, bit ce);
      return {xs, ra[3:0], we, ws, wa[3:0], pe, ov, bz, dn, ce};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {x_sel, rd_addr, wr_en, wr_src, wr_addr, pool_en, out_valid, busy, done, cfg_err};
   endfunction

   function automatic bit dim_ok(int v, int mx);
      return (v != 0) && (v % 2 == 0) && (v <= mx);
   endfunction

   task automatic clear_stats();
      ov_cnt = 0; busy_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
      max_ra = 0; max_wa = 0; wraps = 0; last_wa = -1;
      ov_idx.delete();
      wa_log.delete();
   endtask

   // One clock: drive at negedge, predict, compare 2 time units later, advance the model
   task automatic cyc(input bit sv, input bit st, input int r, input int c);
      bit xs, we, ws, pe, ov, act, next_err;
      int ra, wa, p;
      logic [15:0] e;
      @(negedge clk);
      sys_valid = sv;
      start     = st;
      cfg_rows  = 6'(r);
      cfg_cols  = 6'(c);
      xs = 0; we = 0; ws = 0; pe = 0; ov = 0; ra = 0; wa = 0;
      act = (m_state == 1) && sv;
      p = m_col / 2;
      if (act) begin
         if ((m_row % 2 == 0) && (m_col % 2 == 0)) begin
            we = 1; wa = p;
         end else if ((m_row % 2) != (m_col % 2)) begin
            pe = 1; xs = 1; ra = p; we = 1; ws = 1; wa = p;
         end else begin
            pe = 1; xs = 1; ra = p; ov = 1;
         end
      end
      sb.push_back(pack(xs, ra, we, ws, wa, pe, ov, m_state == 1, m_state == 2, m_err));
      #2;
      e = sb.pop_front();
      chk("ctrl_vec", obs_vec(), e);
`ifdef POOL_SEQ_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (out_valid) begin ov_cnt++; ov_idx.push_back(m_elem); end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (pool_en && int'(rd_addr) > max_ra) max_ra = int'(rd_addr);
      if (wr_en) begin
         wr_cnt++;
         if (wa_log.size() < 4) wa_log.push_back(int'(wr_addr));
         if (int'(wr_addr) > max_wa) max_wa = int'(wr_addr);
         if (last_wa == 15 && wr_addr == 4'd0) wraps++;
         last_wa = int'(wr_addr);
      end
      next_err = 0;
      case (m_state)
         0: if (st) begin
            if (dim_ok(r, 32) && dim_ok(c, 32)) begin
               m_rows = r; m_cols = c; m_row = 0; m_col = 0; m_elem = 0; m_stall = 0; m_state = 1;
            end else begin
               next_err = 1;
            end
         end
         1: if (sv) begin
            m_elem++;
            if (m_col == m_cols - 1) begin
               m_col = 0;
               if (m_row == m_rows - 1) m_state = 2;
               else m_row++;
            end else begin
               m_col++;
            end
         end else if (m_stall < 16'hFFFF) begin
            m_stall++;
         end
         default: m_state = 0;
      endcase
      m_err = next_err;
   endtask

   task automatic run_map(input int r, input int c, input bit gaps);
      cyc(0, 1, r, c);
      for (int i = 0; i < r * c; i++) begin
         cyc(1, 0, 0, 0);
         if (gaps && i != r * c - 1) cyc(0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   initial begin
      int exp_idx[4];
      int exp_wa[4];
      exp_idx = '{5, 7, 13, 15};
      exp_wa  = '{0, 0, 1, 1};

      // Reset state
      #1 nrst = 1'b0;
      #1 chk("reset_vec", obs_vec(), 16'h0000);
      @(negedge clk);
      nrst = 1'b1;
      cyc(0, 0, 0, 0);

      // 4x4 continuous
      clear_stats();
      run_map(4, 4, 0);
      chk("c44_ov_cnt", ov_cnt, 4);
      if (ov_idx.size() == 4)
         for (int i = 0; i < 4; i++) chk("c44_ov_idx", ov_idx[i], exp_idx[i]);
      if (wa_log.size() == 4)
         for (int i = 0; i < 4; i++) chk("c44_wr_addr_row0", wa_log[i], exp_wa[i]);
      chk("c44_busy_cycles", busy_cnt, 16);
      chk("c44_done_cnt", done_cnt, 1);
      chk("c44_wr_cnt", wr_cnt, 12);
`ifdef POOL_SEQ_STALL_CNT_EN
      chk("c44_stall", stall_cnt, 0);
`endif

      // Rejected configurations
      clear_stats();
      cyc(0, 1, 4, 3);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 4);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 34, 4);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("bad_cfg_err_cnt", err_cnt, 3);
      chk("bad_cfg_wr_cnt", wr_cnt, 0);
      chk("bad_cfg_busy", busy_cnt, 0);

      // 4x4 with alternating gaps
      clear_stats();
      run_map(4, 4, 1);
      chk("g44_ov_cnt", ov_cnt, 4);
      chk("g44_busy_cycles", busy_cnt, 31);
      chk("g44_wr_cnt", wr_cnt, 12);
`ifdef POOL_SEQ_STALL_CNT_EN
      chk("g44_stall", stall_cnt, 15);
`endif

      // start mid-run with a different configuration is ignored
      clear_stats();
      cyc(0, 1, 4, 4);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 2, 2);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("mid_start_ov_cnt", ov_cnt, 4);
      chk("mid_start_busy", busy_cnt, 16);
      chk("mid_start_done", done_cnt, 1);

      // Asynchronous reset at element 6 of an 8x8 map
      clear_stats();
      cyc(0, 1, 8, 8);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
      @(negedge clk);
      sys_valid = 1'b1;
      #1 nrst = 1'b0;
      #1 chk("async_rst_vec", obs_vec(), 16'h0000);
`ifdef POOL_SEQ_STALL_CNT_EN
      chk("async_rst_stall", stall_cnt, 0);
`endif
      m_state = 0; m_err = 0; m_stall = 0;
      @(negedge clk);
      sys_valid = 1'b0;
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      chk("async_rst_no_done", done_cnt, 0);
      clear_stats();
      run_map(2, 2, 0);
      chk("r22_ov_cnt", ov_cnt, 1);
      if (ov_idx.size() == 1) chk("r22_ov_idx", ov_idx[0], 3);
      chk("r22_done", done_cnt, 1);

      // 32x32 full-size map
      clear_stats();
      run_map(32, 32, 0);
      chk("m32_ov_cnt", ov_cnt, 256);
      chk("m32_max_rd_addr", max_ra, 15);
      chk("m32_max_wr_addr", max_wa, 15);
      chk("m32_addr_wraps", wraps, 31);
      chk("m32_wr_cnt", wr_cnt, 768);
      chk("m32_busy", busy_cnt, 1024);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pool_seq_ctrl.md
Name: pool_seq_ctrl

Overview:
- Sequencer for the max/avg pooling datapath: the pooling unit, its partial-result register file and the sys_out/feedback input mux.
- Counts row-major systolic outputs of one feature map and drives mux select, register-file read/write addresses, write source, pooling enable and result-valid.
- Fixed window 2x2, stride 2; runtime-configurable map size.
- Mode-agnostic: it sequences only, and the pooling unit applies max or avg.

Parameters:
- MAX_COLS, 32, largest supported map width (even).
- MAX_ROWS, 32, largest supported map height (even).
- DIM_W, 6, width of cfg_rows/cfg_cols; must hold MAX_ROWS and MAX_COLS.
- ADDR_W, 4, register-file address width; 2**ADDR_W >= MAX_COLS/2.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; latch config and begin a map.
- cfg_rows  in  DIM_W  map height.
- cfg_cols  in  DIM_W  map width.
- sys_valid  in  1  sys_out carries a valid element this cycle.
- x_sel  out  1  1 = pooling in1 takes sys_out; 0 = takes fed-back out.
- rd_addr  out  ADDR_W  register-file read address (partial for current column pair).
- wr_en  out  1  register-file write strobe.
- wr_src  out  1  0 = write sys_out; 1 = write pooling out.
- wr_addr  out  ADDR_W  register-file write address.
- pool_en  out  1  pooling unit enable.
- out_valid  out  1  pooling out is a final window result.
- busy  out  1  state is RUN.
- done  out  1  1-cycle pulse, map complete.
- cfg_err  out  1  1-cycle pulse, start rejected.

Behaviour:
- Reset: all of the following are 0 and state is IDLE.
  - Outputs: x_sel, rd_addr, wr_en, wr_src, wr_addr, pool_en, out_valid, busy, done, cfg_err.
  - Counters: row, col.
  - Latched config.
  - Reset mid-run aborts the map immediately; no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start with valid cfg: latch cfg, clear row/col, go RUN.
  - start with invalid cfg: pulse cfg_err next cycle, stay IDLE. Invalid means zero, odd, or above MAX_ROWS/MAX_COLS.
  - sys_valid is ignored.
- RUN:
  - busy=1.
  - Each cycle with sys_valid=1 consumes one element at (row,col). Let p = col>>1.
  - row even, col even: wr_en=1, wr_src=0, wr_addr=p, pool_en=0.
  - row even, col odd: pool_en=1, x_sel=1, rd_addr=p, wr_en=1, wr_src=1, wr_addr=p.
  - row odd, col even: same as the row-even, col-odd case.
  - row odd, col odd: pool_en=1, x_sel=1, rd_addr=p, wr_en=0, out_valid=1.
  - Decode timing: controls are decoded combinationally from the registered counters and sys_valid, in the same cycle as the element (zero latency). All controls are 0 when sys_valid=0.
  - Counter advance on a clock edge with sys_valid: col++. When col==cfg_cols-1, col wraps to 0 and row++.
  - On consuming element (cfg_rows-1, cfg_cols-1), go DONE.
  - sys_valid gaps of any length stall the counters and hold state.
  - start during RUN is ignored; config is not re-latched.
- DONE: done=1 for one cycle, busy=0, then IDLE. start is ignored in DONE.
- Totals per map:
  - out_valid asserts exactly (cfg_rows/2)*(cfg_cols/2) times.
  - wr_en asserts 3 times per window.
- cfg_err and done never assert in the same cycle.

Optional Feature:
- Macro: POOL_SEQ_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits).
  - Counts RUN cycles with sys_valid=0, saturating at 16'hFFFF.
  - Cleared on reset and on an accepted start.
  - Holds its value after DONE until the next accepted start.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- 4x4 map, sys_valid continuous:
  - out_valid exactly 4 times, at element indices 5, 7, 13, 15.
  - wr_addr sequence in row 0 is 0, 0, 1, 1.
  - done pulses the cycle after element 15; busy is high for 16 cycles.
- cfg_cols=3 (and separately cfg_rows=0): cfg_err pulses once, state stays IDLE, no writes.
- 4x4 map with sys_valid toggling 1-0-1-0: same control sequence as the continuous case, spread over 31 cycles, with no controls asserted in gap cycles.
  - Stall feature on: stall_cnt=15.
- start pulsed mid-RUN with a different cfg: ignored; map finishes with the original dimensions.
- Deassert nrst at element 6 of an 8x8 map: all outputs 0 asynchronously, no done.
  - A new start with 2x2 afterwards gives one out_valid at element 3.
- 32x32 map: 256 out_valid pulses; rd_addr/wr_addr reach 15 and wrap to 0 at each row.
